// File: rtl/rv_mc_pkg.sv
// Shared types and constants for the multicycle RISC-V datapath.
//   - select encodings for the result, SrcA, SrcB, ALU and immediate muxes
//   - memory-port FSM state type
//   - PC increment constant
package rv_mc_pkg;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_MDR    = 2'b01,
        RES_ALURES = 2'b10,
        RES_RSVD   = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_A     = 2'b10,
        SRCA_RSVD  = 2'b11
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_B    = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10,
        SRCB_RSVD = 2'b11
    } alu_src_b_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/rv_alu.sv
// XLEN-wide ALU with zero/neg/carry/ovf flags.
//   a_i, b_i   : operands
//   ctl_i      : operation (alu_ctl_e encoding)
//   result_o   : wrapped result
//   zero_o/neg_o/carry_o/ovf_o : flags, combinational
module rv_alu
    import rv_mc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      ctl_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            neg_o,
    output logic            carry_o,
    output logic            ovf_o
);
    localparam int SHW = $clog2(XLEN);

    alu_ctl_e        op;
    logic            is_sub;
    logic            is_arith;
    logic [XLEN-1:0] b_op;
    logic [XLEN:0]   sum_ext;

    always_comb begin
        op       = alu_ctl_e'(ctl_i);
        is_sub   = (op == ALU_SUB);
        is_arith = (op == ALU_ADD) || (op == ALU_SUB);
        // Subtract as a + ~b + 1 so the top bit is the not-borrow.
        b_op     = is_sub ? ~b_i : b_i;
        sum_ext  = {1'b0, a_i} + {1'b0, b_op} + {{XLEN{1'b0}}, is_sub};

        result_o = '0;
        case (op)
            ALU_ADD, ALU_SUB: result_o = sum_ext[XLEN-1:0];
            ALU_AND:          result_o = a_i & b_i;
            ALU_OR:           result_o = a_i | b_i;
            ALU_XOR:          result_o = a_i ^ b_i;
            ALU_SLT:          result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLL:          result_o = a_i << b_i[SHW-1:0];
            ALU_SRL:          result_o = a_i >> b_i[SHW-1:0];
            default:          result_o = '0;
        endcase

        zero_o  = (result_o == '0);
        neg_o   = result_o[XLEN-1];
        carry_o = is_arith & sum_ext[XLEN];
        // Same-sign operands (after inversion for sub) giving a different-sign result.
        ovf_o   = is_arith & (a_i[XLEN-1] == b_op[XLEN-1]) & (sum_ext[XLEN-1] != a_i[XLEN-1]);
    end

endmodule

// File: rtl/rv_regfile.sv
// 2-read/1-write register file. x0 reads zero; indices >= NREGS are
// dropped on write and read as zero. Contents are not reset.
//   clk             : write clock
//   we_i/wa_i/wd_i  : write port
//   ra1_i/rd1_o, ra2_i/rd2_o : asynchronous read ports
module rv_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (we_i && (wa_i != 5'd0) && (int'(wa_i) < NREGS)) begin
            regs_q[wa_i[AW-1:0]] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = ((ra1_i != 5'd0) && (int'(ra1_i) < NREGS)) ? regs_q[ra1_i[AW-1:0]] : '0;
        rd2_o = ((ra2_i != 5'd0) && (int'(ra2_i) < NREGS)) ? regs_q[ra2_i[AW-1:0]] : '0;
    end

endmodule

// File: rtl/rv_mc_datapath.sv
// Multicycle RISC-V datapath: PC/OldPC/IR/MDR/A/B/ALUOut, register file,
// ALU, immediate extension, mcycle/minstret, and a stalling valid/ready
// port to a unified instruction/data memory.
//   clk, rst                      : clock, async active-high reset
//   ResultSrc..MemWe              : control inputs from the controller FSM
//   mem_valid/we/addr/wdata       : memory request
//   mem_ready/mem_rdata           : memory response
//   Instr, zero/neg/carry/ovf     : to the controller
//   stall                         : access outstanding, controller holds
//   mcycle, minstret              : performance counters
module rv_mc_datapath
    import rv_mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      ResultSrc,
    input  logic [1:0]      ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [2:0]      ALUControl,
    input  logic [2:0]      ImmSrc,
    input  logic            RegWrite,
    input  logic            PCWrite,
    input  logic            IRWrite,
    input  logic            AdrSrc,
    input  logic            MemReq,
    input  logic            MemWe,
    output logic            mem_valid,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [31:0]     Instr,
    output logic            zero,
    output logic            neg,
    output logic            carry,
    output logic            ovf,
    output logic            stall,
    output logic [63:0]     mcycle,
    output logic [63:0]     minstret
);
    logic [XLEN-1:0] pc_q, oldpc_q, mdr_q, a_q, b_q, aluout_q;
    logic [31:0]     ir_q;
    logic [63:0]     mcycle_q, minstret_q;
    mem_state_e      state_q;
    logic [XLEN-1:0] hold_addr_q;
    logic            hold_we_q;

    logic [XLEN-1:0] rd1, rd2, src_a, src_b, alu_res, result, imm_ext, addr_c;
    logic signed [31:0] imm32;
    logic            busy, rd_done;

    // Immediates are built at 32 bits then sign-extended to XLEN by the cast.
    always_comb begin
        imm32 = '0;
        case (imm_src_e'(ImmSrc))
            IMM_I:   imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            IMM_S:   imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            IMM_B:   imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            IMM_J:   imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            IMM_U:   imm32 = {ir_q[31:12], 12'b0};
            default: imm32 = '0;
        endcase
        imm_ext = XLEN'(imm32);
    end

    always_comb begin
        src_a = '0;
        case (alu_src_a_e'(ALUSrcA))
            SRCA_PC:    src_a = pc_q;
            SRCA_OLDPC: src_a = oldpc_q;
            SRCA_A:     src_a = a_q;
            default:    src_a = '0;
        endcase
        src_b = '0;
        case (alu_src_b_e'(ALUSrcB))
            SRCB_B:    src_b = b_q;
            SRCB_IMM:  src_b = imm_ext;
            SRCB_FOUR: src_b = XLEN'(PC_INC);
            default:   src_b = '0;
        endcase
        result = '0;
        case (result_src_e'(ResultSrc))
            RES_ALUOUT: result = aluout_q;
            RES_MDR:    result = mdr_q;
            RES_ALURES: result = alu_res;
            default:    result = '0;
        endcase
    end

    rv_alu #(.XLEN(XLEN)) u_alu (
        .a_i      (src_a),
        .b_i      (src_b),
        .ctl_i    (ALUControl),
        .result_o (alu_res),
        .zero_o   (zero),
        .neg_o    (neg),
        .carry_o  (carry),
        .ovf_o    (ovf)
    );

    rv_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .we_i  (RegWrite && !stall),
        .wa_i  (ir_q[11:7]),
        .wd_i  (result),
        .ra1_i (ir_q[19:15]),
        .ra2_i (ir_q[24:20]),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    // Memory port. In WAIT the captured address/direction are replayed so the
    // request cannot drift; B already holds during a stall.
    always_comb begin
        busy      = (state_q == MEM_WAIT);
        addr_c    = AdrSrc ? result : pc_q;
        mem_valid = !rst && (busy || MemReq);
        mem_addr  = busy ? hold_addr_q : addr_c;
        mem_we    = mem_valid && (busy ? hold_we_q : MemWe);
        mem_wdata = b_q;
        stall     = mem_valid && !mem_ready;
        rd_done   = mem_valid && mem_ready && !mem_we;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MEM_IDLE;
            hold_addr_q <= '0;
            hold_we_q   <= 1'b0;
            pc_q        <= RESET_PC;
            oldpc_q     <= '0;
            ir_q        <= '0;
            mdr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            aluout_q    <= '0;
            mcycle_q    <= '0;
            minstret_q  <= '0;
        end else begin
            mcycle_q <= mcycle_q + 64'd1;

            case (state_q)
                MEM_IDLE: if (MemReq && !mem_ready) begin
                    state_q     <= MEM_WAIT;
                    hold_addr_q <= addr_c;
                    hold_we_q   <= MemWe;
                end
                MEM_WAIT: if (mem_ready) state_q <= MEM_IDLE;
                default:  state_q <= MEM_IDLE;
            endcase

            if (!stall) begin
                a_q      <= rd1;
                b_q      <= rd2;
                aluout_q <= alu_res;
                if (PCWrite) pc_q <= result;
                if (IRWrite) minstret_q <= minstret_q + 64'd1;
                if (rd_done) begin
                    mdr_q <= mem_rdata;
                    if (IRWrite) begin
                        ir_q    <= mem_rdata[31:0];
                        oldpc_q <= pc_q;
                    end
                end
            end
        end
    end

    assign Instr    = ir_q;
    assign mcycle   = mcycle_q;
    assign minstret = minstret_q;

endmodule

// File: tb/tb_rv_mc_datapath.sv
// Directed bench for rv_mc_datapath: a 32-bit RV32E instance (NREGS=16)
// and a 64-bit instance share the control inputs and mem_ready.
module tb_rv_mc_datapath;
    logic        clk, rst;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ALUControl, ImmSrc;
    logic        RegWrite, PCWrite, IRWrite, AdrSrc, MemReq, MemWe;
    logic        mem_ready;
    logic [31:0] rdata32;
    logic [63:0] rdata64;

    logic        mem_valid, mem_we, zero, neg, carry, ovf, stall;
    logic [31:0] mem_addr, mem_wdata, Instr;
    logic [63:0] mcycle, minstret;

    logic        w_valid, w_we, w_zero, w_neg, w_carry, w_ovf, w_stall;
    logic [63:0] w_addr, w_wdata, w_mcycle, w_minstret;
    logic [31:0] w_instr;

    int n_chk = 0;
    int n_fail = 0;

    rv_mc_datapath #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0)) u32 (
        .clk(clk), .rst(rst), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .PCWrite(PCWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemReq(MemReq), .MemWe(MemWe),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(rdata32), .Instr(Instr), .zero(zero), .neg(neg),
        .carry(carry), .ovf(ovf), .stall(stall), .mcycle(mcycle), .minstret(minstret)
    );

    rv_mc_datapath #(.XLEN(64), .NREGS(32), .RESET_PC(64'h0)) u64 (
        .clk(clk), .rst(rst), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .PCWrite(PCWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemReq(MemReq), .MemWe(MemWe),
        .mem_valid(w_valid), .mem_we(w_we), .mem_addr(w_addr), .mem_wdata(w_wdata),
        .mem_ready(mem_ready), .mem_rdata(rdata64), .Instr(w_instr), .zero(w_zero), .neg(w_neg),
        .carry(w_carry), .ovf(w_ovf), .stall(w_stall), .mcycle(w_mcycle), .minstret(w_minstret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl_clr();
        ResultSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ALUControl = 3'b000;
        ImmSrc = 3'b000; RegWrite = 0; PCWrite = 0; IRWrite = 0; AdrSrc = 0;
        MemReq = 0; MemWe = 0;
    endtask

    // Fetch at PC=pc with `waits` wait states; PC <= PC + 4 on completion.
    task automatic fetch(input logic [31:0] ins, input int waits, input logic [63:0] pc);
        ctl_clr();
        MemReq = 1; IRWrite = 1; PCWrite = 1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        rdata32 = ins; rdata64 = {32'h0, ins}; mem_ready = 0;
        #1;
        chk("f_addr", mem_addr, pc);
        for (int i = 0; i < waits; i++) begin
            chk("ws_stall", stall, 1);
            chk("ws_addr", mem_addr, pc);
            chk("ws_pc", u32.pc_q, pc);
            step();
        end
        mem_ready = 1;
        #1;
        chk("f_nostall", stall, 0);
        chk("f_valid", mem_valid, 1);
        step();
        ctl_clr(); mem_ready = 0;
        #1;
        chk("f_ir", Instr, ins);
        chk("f_pc", mem_addr, pc + 64'd4);
    endtask

    // Read v into MDR, write it to rd = Instr[11:7], then let A/B reload.
    task automatic load_reg(input logic [63:0] v);
        ctl_clr(); MemReq = 1; AdrSrc = 1; mem_ready = 1; rdata32 = v[31:0]; rdata64 = v;
        step();
        ctl_clr(); mem_ready = 0; ResultSrc = 2'b01; RegWrite = 1;
        step();
        ctl_clr();
        step();
    endtask

    // A=B=0xF0000003, I-imm=1, const 4
    logic [2:0]  t_op  [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd1};
    logic [1:0]  t_sb  [8] = '{2'd2, 2'd2, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    logic [31:0] t_exp [8] = '{32'h0, 32'hF0000007, 32'hF0000002, 32'h0, 32'h1,
                               32'hE0000006, 32'h78000001, 32'hEFFFFFFF};
    logic        t_cy  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        ctl_clr();
        rst = 1; mem_ready = 0; rdata32 = '0; rdata64 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", mem_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_pc", mem_addr, 0);
        chk("rst_ir", Instr, 0);
        chk("rst_mcycle", mcycle, 0);
        chk("rst_minstret", minstret, 0);
        rst = 0;

        // zero-wait fetch of addi x1,x0,5
        fetch(32'h00500093, 0, 64'h0);
        chk("fetch_minstret", minstret, 1);
        chk("fetch_mcycle", mcycle, 1);

        // 3 wait states: addi x1,x1,1
        fetch(32'h00108093, 3, 64'h4);
        chk("ws_minstret", minstret, 2);
        chk("ws_mcycle", mcycle, 5);

        // 0x7FFFFFFF + 1
        load_reg(64'h7FFFFFFF);
        chk("rf_b", mem_wdata, 32'h7FFFFFFF);
        chk("ld_minstret", minstret, 2);
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = 3'b000; ALUControl = 3'b000;
        ResultSrc = 2'b10; AdrSrc = 1;
        #1;
        chk("add_res", mem_addr, 32'h80000000);
        chk("add_ovf", ovf, 1);
        chk("add_neg", neg, 1);
        chk("add_carry", carry, 0);
        chk("add_zero", zero, 0);
        step();
        ResultSrc = 2'b00;
        #1;
        chk("aluout", mem_addr, 32'h80000000);
        ctl_clr();

        load_reg(64'hF0000003);
        for (int i = 0; i < 8; i++) begin
            ALUSrcA = 2'b10; ALUSrcB = t_sb[i]; ALUControl = t_op[i];
            ResultSrc = 2'b10; AdrSrc = 1;
            #1;
            chk($sformatf("op%0d_res", i), mem_addr, t_exp[i]);
            chk($sformatf("op%0d_cy", i), carry, t_cy[i]);
            chk($sformatf("op%0d_ovf", i), ovf, 0);
        end
        ctl_clr();

        // 5 - 5
        load_reg(64'd5);
        ALUSrcA = 2'b10; ALUSrcB = 2'b00; ALUControl = 3'b001; ResultSrc = 2'b10; AdrSrc = 1;
        #1;
        chk("sub_res", mem_addr, 0);
        chk("sub_zero", zero, 1);
        chk("sub_carry", carry, 1);
        chk("sub_ovf", ovf, 0);
        ctl_clr();

        // x0 ignores writes: add x0,x0,x0
        fetch(32'h00000033, 0, 64'h8);
        load_reg(64'hDEAD);
        chk("x0_read", mem_wdata, 0);
        // RV32E: add x20,x0,x20
        fetch(32'h01400A33, 0, 64'hC);
        load_reg(64'hBEEF);
        chk("x20_read", mem_wdata, 0);

        // reset while an access is waiting
        ctl_clr(); MemReq = 1; IRWrite = 1; PCWrite = 1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        rdata32 = 32'h12345678; rdata64 = 64'h12345678; mem_ready = 0;
        step();
        chk("mid_stall", stall, 1);
        rst = 1;
        #1;
        chk("mid_valid", mem_valid, 0);
        chk("mid_nostall", stall, 0);
        chk("mid_pc", mem_addr, 0);
        chk("mid_ir", Instr, 0);
        mem_ready = 1;
        step();
        rst = 0; ctl_clr(); mem_ready = 0;
        step();
        chk("mid_discard", Instr, 0);
        chk("mid_minstret", minstret, 0);

        // XLEN=64: addi x0,x0,-1 -> I-imm 0xFFF
        fetch(32'hFFF00013, 0, 64'h0);
        step();
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = 3'b000; ALUControl = 3'b000;
        ResultSrc = 2'b10; AdrSrc = 1;
        #1;
        chk("imm64_i", w_addr, 64'hFFFFFFFFFFFFFFFF);
        chk("imm32_i", mem_addr, 32'hFFFFFFFF);
        ImmSrc = 3'b100;
        #1;
        chk("imm64_u", w_addr, 64'hFFFFFFFFFFF00000);
        ctl_clr();

        // add x5,x0,x5 then store B
        fetch(32'h005002B3, 0, 64'h4);
        load_reg(64'h123456789ABCDEF0);
        MemReq = 1; MemWe = 1; AdrSrc = 1; mem_ready = 1;
        #1;
        chk("st_valid", w_valid, 1);
        chk("st_we", w_we, 1);
        chk("st_wdata", w_wdata, 64'h123456789ABCDEF0);
        step();
        ctl_clr(); mem_ready = 0;
        #1;
        chk("st_idle_we", w_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_mc_datapath.md
# rv_mc_datapath

Parametrised multicycle RISC-V datapath with an internal instruction register, a memory data register and a stalling valid/ready memory port. Holds PC, OldPC, IR, MDR, A, B and ALUOut, plus the register file and the `mcycle`/`minstret` counters. Sits between the multicycle controller FSM, which drives the control inputs, and a unified instruction/data memory with variable latency.

## Interface
- `XLEN`, 32: datapath width. Legal values are 32 and 64.
- `NREGS`, 32: architectural register count. 16 selects RV32E.
- `RESET_PC`, 0: PC value after reset.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `ResultSrc` in 2: result mux select. 00 ALUOut, 01 MDR, 10 ALUResult, 11 reserved (drives 0).
- `ALUSrcA` in 2: SrcA select. 00 PC, 01 OldPC, 10 A, 11 reserved (drives 0).
- `ALUSrcB` in 2: SrcB select. 00 B, 01 ImmExt, 10 constant 4, 11 reserved (drives 0).
- `ALUControl` in 3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- `ImmSrc` in 3: 000 I, 001 S, 010 B, 011 J, 100 U, others produce 0.
- `RegWrite`, `PCWrite`, `IRWrite`, `AdrSrc` in 1 each: architectural write enables and the address select (0 PC, 1 Result).
- `MemReq`, `MemWe` in 1 each: memory access request and its direction for the current state.
- `mem_valid` out 1: request valid.
- `mem_we` out 1: write strobe, equal to `MemWe` while `mem_valid` is high.
- `mem_addr` out XLEN: access address.
- `mem_wdata` out XLEN: write data, equal to B.
- `mem_ready` in 1: memory accepts or completes the access in this cycle.
- `mem_rdata` in XLEN: read data, valid when `mem_ready` is high.
- `Instr` out 32: IR contents, fed to the controller.
- `zero`, `neg`, `carry`, `ovf` out 1 each: combinational ALU flags.
- `stall` out 1: an access is outstanding; the controller must hold all control inputs.
- `mcycle`, `minstret` out 64 each: cycle counter and retired-instruction counter.

## Operation
- **Memory FSM states:**
  - IDLE: `mem_valid` = `MemReq`.
    - `MemReq` & `mem_ready` completes the access in the same cycle and the FSM stays in IDLE.
    - `MemReq` & !`mem_ready` moves to WAIT.
  - WAIT: `mem_valid` = 1. `mem_addr`, `mem_we` and `mem_wdata` are held stable. `mem_ready` returns the FSM to IDLE.
- `stall` = `mem_valid` & !`mem_ready`.
- While `stall` is high:
  - PC, OldPC, IR, regfile, A, B, ALUOut and MDR all hold.
  - PCWrite, IRWrite and RegWrite are suppressed.
- **Read completion:** MDR <= `mem_rdata`. If IRWrite is high, IR <= `mem_rdata[31:0]` and OldPC <= PC.
- A, B and ALUOut load every non-stalled cycle.
- Register x0 reads as 0 and ignores writes.
- Register writes use `Instr[11:7]`. Register indices at or above NREGS are ignored on write and read as 0.
- **Arithmetic:**
  - All ALU operations are XLEN wide and wrap.
  - slt is signed and returns 0 or 1.
  - Shift amount is `SrcB[$clog2(XLEN)-1:0]`.
  - `carry` is the carry-out of add, or the not-borrow of sub.
  - `ovf` is signed overflow for add and sub only, and 0 for other operations.
- **Immediates:** sign-extended to XLEN. U-type places bits [31:12] in position and extends to XLEN.
- **Counters:**
  - `mcycle` increments every cycle out of reset.
  - `minstret` increments once on each non-stalled cycle with IRWrite high.
  - Both wrap at 2^64.
- If `mem_ready` is asserted in IDLE while `MemReq` is low, it is ignored.

## Timing
- **Reset values:**
  - PC = RESET_PC.
  - OldPC, IR, MDR, A, B, ALUOut = 0.
  - Both counters = 0.
  - FSM in IDLE, so `mem_valid` = 0 and `stall` = 0.
  - Register file contents are not reset.
- **Reset mid-access:** the FSM returns to IDLE immediately and `mem_valid` drops asynchronously. The pending read data is discarded.
- **Zero-wait memory:** an access completes in 1 cycle.
- **Latency-N memory:** an access completes after N+1 cycles, with `stall` high for N cycles.
- Flags and ALUResult are valid in the same cycle as their inputs. ALUOut is valid 1 cycle later.
- **Simultaneous PCWrite and IRWrite on the fetch completion:** OldPC captures the old PC and PC captures Result.

## Structure
- Package `rv_mc_pkg` holds:
  - enums for ResultSrc, ALUSrcA, ALUSrcB, ALUControl and ImmSrc;
  - the memory FSM state type;
  - the constant 4.
- Sub-modules are `rv_regfile` (parametrised by XLEN and NREGS, 2R1W, x0 hardwired to zero) and `rv_alu`, which produces the four flags.
- Immediate extension and muxes stay inline.

## Test plan
- **Reset and fetch:** hold `rst`, release it, then fetch with zero-wait memory.
  - `mem_addr` = 0 and `mem_rdata` = 0x00500093 (addi x1,x0,5).
  - Required: IR = 0x00500093, PC = 4, `minstret` = 1.
- **Wait states:** memory with 3 wait states.
  - Required: `stall` high for exactly 3 cycles, `mem_addr` stable throughout, PC updates only on the `mem_ready` cycle.
- **Reset mid-access:** assert `rst` in WAIT.
  - Required: `mem_valid` = 0 immediately, PC = RESET_PC, IR = 0.
- **ALU flags:** drive 0x7FFFFFFF + 1 at XLEN=32.
  - Required: result 0x80000000, `ovf` = 1, `neg` = 1, `carry` = 0.
  - Then drive 5 - 5. Required: `zero` = 1, `carry` = 1.
- **x0 and RV32E:** write 0xDEAD to x0, and with NREGS=16 write to x20.
  - Required: both registers read 0.
- **XLEN=64:** run the immediate path with I-imm 0xFFF.
  - Required: ImmExt = 0xFFFFFFFFFFFFFFFF. A store drives `mem_we` = 1 and `mem_wdata` = B.
